// File: rtl/rgb_pwm_pkg.sv
// Shared lights definitions: PWM width and colour channel slices.
// Used by the selector path and the RGB PWM fader.
package rgb_pwm_pkg;

  localparam int PWM_BITS = 8;
  localparam int R_LSB    = 16;
  localparam int G_LSB    = 8;
  localparam int B_LSB    = 0;

  typedef logic [PWM_BITS-1:0] duty_t;

  function automatic duty_t chan(input logic [23:0] c, input int lsb);
    return c[lsb +: PWM_BITS];
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One colour channel: target register, ramping current duty,
// period-locked active duty and registered PWM output.
module pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic  i_clk,
  input  logic  i_rst,
  input  logic  i_enable,
  input  logic  i_tick,
  input  logic  i_wrap,
  input  duty_t i_cnt,
  input  duty_t i_light,
  output duty_t o_cur,
  output logic  o_led,
  output logic  o_settled
);

  duty_t r_tgt;
  duty_t r_cur;
  duty_t r_act;
  logic  r_led;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tgt <= '0;
      r_cur <= '0;
      r_act <= '0;
      r_led <= 1'b0;
    end else begin
      r_tgt <= i_light;
      if (i_tick) begin
        if (r_cur < r_tgt)
          r_cur <= r_cur + 8'd1;
        else if (r_cur > r_tgt)
          r_cur <= r_cur - 8'd1;
      end
      // act samples cur before this edge's step
      if (i_wrap)
        r_act <= r_cur;
      r_led <= i_enable && (i_cnt < r_act);
    end
  end

  assign o_cur     = r_cur;
  assign o_led     = r_led;
  assign o_settled = (r_cur == r_tgt);

endmodule

// File: rtl/rgb_pwm.sv
// RGB PWM driver with linear fade toward the selected colour.
// Shares one period counter and fade prescaler across three channels.
module rgb_pwm
  import rgb_pwm_pkg::*;
#(
  parameter int FADE_DIV = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] light,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic [23:0] level,
  output logic        settled
);

  localparam logic [15:0] PRE_MAX = 16'(FADE_DIV - 1);

  duty_t       r_cnt;
  logic [15:0] r_pre;
  logic        w_tick;
  logic        w_wrap;
  duty_t       w_cur_r, w_cur_g, w_cur_b;
  logic        w_set_r, w_set_g, w_set_b;

  assign w_tick = enable && (r_pre == PRE_MAX);
  assign w_wrap = enable && (r_cnt == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_pre <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 8'd1;
      r_pre <= w_tick ? 16'd0 : r_pre + 16'd1;
    end
  end

  pwm_channel u_r (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_enable  (enable),
    .i_tick    (w_tick),
    .i_wrap    (w_wrap),
    .i_cnt     (r_cnt),
    .i_light   (chan(light, R_LSB)),
    .o_cur     (w_cur_r),
    .o_led     (led_r),
    .o_settled (w_set_r)
  );

  pwm_channel u_g (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_enable  (enable),
    .i_tick    (w_tick),
    .i_wrap    (w_wrap),
    .i_cnt     (r_cnt),
    .i_light   (chan(light, G_LSB)),
    .o_cur     (w_cur_g),
    .o_led     (led_g),
    .o_settled (w_set_g)
  );

  pwm_channel u_b (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_enable  (enable),
    .i_tick    (w_tick),
    .i_wrap    (w_wrap),
    .i_cnt     (r_cnt),
    .i_light   (chan(light, B_LSB)),
    .o_cur     (w_cur_b),
    .o_led     (led_b),
    .o_settled (w_set_b)
  );

  assign level   = {w_cur_r, w_cur_g, w_cur_b};
  assign settled = w_set_r && w_set_g && w_set_b;

endmodule

// File: tb/tb_rgb_pwm.sv
// Directed bench for rgb_pwm with FADE_DIV=4.
module tb_rgb_pwm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] light = '0;
  logic        led_r, led_g, led_b;
  logic [23:0] level;
  logic        settled;

  int vecs = 0;
  int errs = 0;

  rgb_pwm #(.FADE_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .light   (light),
    .led_r   (led_r),
    .led_g   (led_g),
    .led_b   (led_b),
    .level   (level),
    .settled (settled)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enable = 1'b0;
    light = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_settle(input string nm);
    bit got;
    got = 0;
    step(1);
    for (int k = 0; k < 1200; k++) begin
      if (settled) begin
        got = 1;
        break;
      end
      step(1);
    end
    vecs++;
    if (got !== 1'b1) begin
      errs++;
      $display("FAIL %s settle timeout level=%h", nm, level);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b1;
    light = 24'hFFFFFF;
    step(3);
    vecs++;
    if (level !== 24'h0) begin
      errs++;
      $display("FAIL reset_level got=%h exp=000000", level);
    end
    vecs++;
    if (settled !== 1'b1) begin
      errs++;
      $display("FAIL reset_settled got=%b exp=1", settled);
    end
    vecs++;
    if ({led_r, led_g, led_b} !== 3'b000) begin
      errs++;
      $display("FAIL reset_leds got=%b exp=000", {led_r, led_g, led_b});
    end
    vecs++;
    if (dut.r_cnt !== 8'd0 || dut.r_pre !== 16'd0) begin
      errs++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", dut.r_cnt, dut.r_pre);
    end
  endtask

  task automatic test_fade_up();
    logic [7:0] e;
    do_reset();
    light = 24'hFFFFFF;
    enable = 1'b1;
    for (int n = 1; n <= 1020; n++) begin
      step(1);
      e = 8'(n / 4);
      vecs++;
      if (level !== {e, e, e}) begin
        errs++;
        $display("FAIL fade_level edge=%0d got=%h exp=%h", n, level, {e, e, e});
      end
      vecs++;
      if (settled !== (n == 1020)) begin
        errs++;
        $display("FAIL fade_settled edge=%0d got=%b exp=%b", n, settled, n == 1020);
      end
    end
  endtask

  task automatic test_duty_half();
    int hr, hg, hb;
    light = 24'h800000;
    wait_settle("duty80");
    step(512);
    vecs++;
    if (level !== 24'h800000) begin
      errs++;
      $display("FAIL duty80_level got=%h exp=800000", level);
    end
    hr = 0; hg = 0; hb = 0;
    for (int k = 0; k < 256; k++) begin
      step(1);
      hr += int'(led_r);
      hg += int'(led_g);
      hb += int'(led_b);
    end
    vecs++;
    if (hr != 128) begin
      errs++;
      $display("FAIL duty80_r got=%0d exp=128", hr);
    end
    vecs++;
    if (hg != 0 || hb != 0) begin
      errs++;
      $display("FAIL duty80_gb got=%0d/%0d exp=0/0", hg, hb);
    end
  endtask

  task automatic test_duty_full();
    int hr, hg, hb;
    logic [7:0] lowcnt;
    light = 24'h00FF00;
    wait_settle("dutyff");
    step(512);
    hr = 0; hg = 0; hb = 0;
    lowcnt = 8'hAA;
    for (int k = 0; k < 256; k++) begin
      step(1);
      hr += int'(led_r);
      hg += int'(led_g);
      hb += int'(led_b);
      if (!led_g) lowcnt = dut.r_cnt;
    end
    vecs++;
    if (hg != 255) begin
      errs++;
      $display("FAIL dutyff_g got=%0d exp=255", hg);
    end
    vecs++;
    if (hr != 0 || hb != 0) begin
      errs++;
      $display("FAIL dutyff_rb got=%0d/%0d exp=0/0", hr, hb);
    end
    // low sample follows the cnt=255 compare, so cnt has just wrapped
    vecs++;
    if (lowcnt !== 8'd0) begin
      errs++;
      $display("FAIL dutyff_lowpos got=%0d exp=0", lowcnt);
    end
  endtask

  task automatic test_retarget();
    bit got, mono;
    logic [7:0] prev;
    do_reset();
    light = 24'hFF0000;
    enable = 1'b1;
    got = 0;
    for (int k = 0; k < 400; k++) begin
      step(1);
      if (level[23:16] == 8'h40) begin
        got = 1;
        break;
      end
    end
    vecs++;
    if (!got) begin
      errs++;
      $display("FAIL retgt_reach got=%h exp=40", level[23:16]);
    end
    light = 24'h200000;
    step(3);
    vecs++;
    if (level[23:16] !== 8'h40) begin
      errs++;
      $display("FAIL retgt_hold got=%h exp=40", level[23:16]);
    end
    step(1);
    vecs++;
    if (level[23:16] !== 8'h3F) begin
      errs++;
      $display("FAIL retgt_first got=%h exp=3f", level[23:16]);
    end
    mono = 1;
    prev = level[23:16];
    for (int k = 0; k < 124; k++) begin
      step(1);
      if (level[23:16] > prev) mono = 0;
      prev = level[23:16];
    end
    vecs++;
    if (!mono) begin
      errs++;
      $display("FAIL retgt_mono got=nonmonotonic exp=monotonic");
    end
    vecs++;
    if (level !== 24'h200000 || settled !== 1'b1) begin
      errs++;
      $display("FAIL retgt_end got=%h/%b exp=200000/1", level, settled);
    end
    step(40);
    vecs++;
    if (level !== 24'h200000) begin
      errs++;
      $display("FAIL retgt_stay got=%h exp=200000", level);
    end
  endtask

  task automatic test_async_reset();
    bit got;
    do_reset();
    light = 24'hFFFFFF;
    enable = 1'b1;
    step(600);
    got = 0;
    for (int k = 0; k < 256; k++) begin
      if (led_r) begin
        got = 1;
        break;
      end
      step(1);
    end
    vecs++;
    if (!got) begin
      errs++;
      $display("FAIL arst_precond got=%b exp=1", led_r);
    end
    #2 rst = 1'b1;
    #1;
    vecs++;
    if ({led_r, led_g, led_b} !== 3'b000) begin
      errs++;
      $display("FAIL arst_leds got=%b exp=000", {led_r, led_g, led_b});
    end
    vecs++;
    if (level !== 24'h0 || settled !== 1'b1) begin
      errs++;
      $display("FAIL arst_level got=%h/%b exp=000000/1", level, settled);
    end
    step(1);
    rst = 1'b0;
  endtask

  task automatic test_enable_hold();
    bit ok;
    do_reset();
    light = 24'hFFFFFF;
    enable = 1'b1;
    step(201);
    vecs++;
    if (level !== 24'h323232 || dut.r_cnt !== 8'd201 || dut.r_pre !== 16'd1) begin
      errs++;
      $display("FAIL hold_pre got=%h/%0d/%0d exp=323232/201/1", level, dut.r_cnt, dut.r_pre);
    end
    enable = 1'b0;
    ok = 1;
    for (int k = 0; k < 100; k++) begin
      step(1);
      if ({led_r, led_g, led_b} !== 3'b000 || level !== 24'h323232) ok = 0;
    end
    vecs++;
    if (!ok) begin
      errs++;
      $display("FAIL hold_frozen got=%h exp=323232 leds low", level);
    end
    vecs++;
    if (dut.r_cnt !== 8'd201 || dut.r_pre !== 16'd1) begin
      errs++;
      $display("FAIL hold_cnt got=%0d/%0d exp=201/1", dut.r_cnt, dut.r_pre);
    end
    enable = 1'b1;
    step(2);
    vecs++;
    if (level !== 24'h323232 || dut.r_cnt !== 8'd203) begin
      errs++;
      $display("FAIL hold_resume1 got=%h/%0d exp=323232/203", level, dut.r_cnt);
    end
    step(1);
    vecs++;
    if (level !== 24'h333333 || dut.r_pre !== 16'd0 || dut.r_cnt !== 8'd204) begin
      errs++;
      $display("FAIL hold_resume2 got=%h/%0d/%0d exp=333333/0/204", level, dut.r_pre, dut.r_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_fade_up();
    test_duty_half();
    test_duty_full();
    test_retarget();
    test_async_reset();
    test_enable_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/rgb_pwm.md
RGB_PWM -- requirements
Module: rgb_pwm

Interface
REQ-001 SHALL have parameter FADE_DIV, default 256: clock cycles per fade step (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port enable, input, 1 bit: run/hold control.
REQ-005 SHALL have port light, input, 24 bits: target colour from the light selector; [23:16] R, [15:8] G, [7:0] B.
REQ-006 SHALL have ports led_r, led_g, led_b, outputs, 1 bit each: registered PWM drive.
REQ-007 SHALL have port level, output, 24 bits: current faded duty {cur_r, cur_g, cur_b}.
REQ-008 SHALL have port settled, output, 1 bit: high when all cur_x equal tgt_x.

Function
REQ-009 SHALL register light into tgt each cycle, so a change is visible to the fader 1 cycle later.
REQ-010 SHALL run an 8-bit period counter cnt, incrementing each cycle while enable=1 and wrapping 255->0; a PWM period is 256 cycles.
REQ-011 SHALL run prescaler pre counting 0..FADE_DIV-1 while enable=1; tick asserted for one cycle when pre=FADE_DIV-1, pre then wraps to 0.
REQ-012 On tick, each channel SHALL step independently: cur+1 if cur<tgt, cur-1 if cur>tgt, hold if equal; no overshoot, no wrap below 0 or above 255.
REQ-013 Target change mid-fade SHALL reverse or retarget on the next tick from the present cur value.
REQ-014 SHALL latch cur_x into active duty act_x only when cnt wraps 255->0, so duty never changes within a period.
REQ-015 led_x SHALL be the registered value of (enable and cnt<act_x): 1-cycle latency from cnt.
REQ-016 act_x=0 SHALL give led_x constantly low; act_x=255 SHALL give led_x high 255 of 256 cycles.
REQ-017 enable=0 SHALL freeze cnt, pre, cur, act; led_x low from the next edge; on re-enable, counting resumes from frozen values.
REQ-018 settled SHALL be combinational from cur and tgt; level SHALL equal cur directly.
REQ-019 Simultaneous tick and period wrap SHALL latch the pre-step cur into act; the step appears at the following wrap.

Reset
REQ-020 rst SHALL asynchronously clear cnt, pre, tgt, cur, act and led_r/g/b to 0, giving level=0 and settled=1.
REQ-021 rst asserted mid-fade or mid-period SHALL force led_x low immediately, not waiting for a clock edge.
REQ-022 After rst deasserts, the first tick SHALL occur FADE_DIV enabled cycles later.

Structure
REQ-023 Channel bit positions (R/G/B slices) and PWM_BITS=8 SHALL live in the shared lights package/include used by the selector path.
REQ-024 SHALL instantiate one sub-module pwm_channel three times, each containing tgt, cur, act and led logic, sharing cnt, pre and tick from the top.

Verification (FADE_DIV=4 unless stated)
REQ-025 Bench SHALL cover: reset, then light=FFFFFF with enable=1 -> cur rises 1 per 4 cycles; settled rises after 255 ticks (~1021 cycles); level=FFFFFF.
REQ-026 Bench SHALL cover: settled at light=800000 -> led_r high exactly 128 of each 256-cycle period; led_g and led_b never high.
REQ-027 Bench SHALL cover: light=00FF00 after settling -> led_g low exactly 1 cycle per period (cnt=255); led_r stays low.
REQ-028 Bench SHALL cover: cur_r=0x40 rising toward 0xFF, then light changed to 0x200000 -> next tick cur_r=0x3F; decreases monotonically to 0x20 and holds.
REQ-029 Bench SHALL cover: rst pulsed between clock edges during fade -> all led_x low and level=0 before the next edge; settled=1.
REQ-030 Bench SHALL cover: enable=0 for 100 cycles mid-fade -> level, cnt and pre unchanged and leds low; resumes with identical timing afterwards.
